// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
// CW must equal $clog2(FIFO_DEPTH+1) of the FIFO instance it connects to.
interface fifo_sync_param_if #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned CW         = 4
);
  logic                  clr;
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CW-1:0]         count;
  logic                  err_sticky;

  modport master (
    output clr, data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, err_sticky
  );

  modport slave (
    input  clr, data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow, full, empty,
           almostfull, almostempty, count, err_sticky
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read,
// occupancy count, synchronous flush and a sticky overflow/underflow flag.
module fifo_sync_param #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int unsigned AE_LEVEL   = 1,
  parameter int unsigned FWFT       = 0
) (
  input logic              clk,
  input logic              rst,
  fifo_sync_param_if.slave fifo_io
);

  localparam int unsigned   CW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned   PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] PtrLast = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] CntFull = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CntAf   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CntAe   = CW'(AE_LEVEL);

  if (FIFO_WIDTH == 0) begin : g_bad_width
    $fatal(1, "fifo_sync_param: FIFO_WIDTH must be >= 1");
  end
  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $fatal(1, "fifo_sync_param: FIFO_DEPTH must be >= 2");
  end
  if (AF_LEVEL == 0 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
    $fatal(1, "fifo_sync_param: AF_LEVEL must be in 1..FIFO_DEPTH");
  end
  if (AE_LEVEL >= FIFO_DEPTH) begin : g_bad_ae
    $fatal(1, "fifo_sync_param: AE_LEVEL must be in 0..FIFO_DEPTH-1");
  end
  if (FWFT > 1) begin : g_bad_fwft
    $fatal(1, "fifo_sync_param: FWFT must be 0 or 1");
  end

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ack_q, wr_ack_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          err_q, err_d;

  logic full_w, empty_w;
  logic wr_ok, rd_ok;
  logic wr_rej, rd_rej;

  // Flags decode from the registered count only.
  always_comb begin
    full_w  = (count_q == CntFull);
    empty_w = (count_q == '0);
  end

  // Acceptance uses pre-edge state; clr overrides both requests.
  always_comb begin
    wr_ok  = fifo_io.wr_en && !full_w  && !fifo_io.clr;
    rd_ok  = fifo_io.rd_en && !empty_w && !fifo_io.clr;
    wr_rej = fifo_io.wr_en &&  full_w  && !fifo_io.clr;
    rd_rej = fifo_io.rd_en &&  empty_w && !fifo_io.clr;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_ack_d = wr_ok;
    ovf_d    = wr_rej;
    udf_d    = rd_rej;
    err_d    = err_q | wr_rej | rd_rej;

    if (fifo_io.clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      err_q    <= err_d;
    end
  end

  // Storage has no reset; occupancy tracking makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= fifo_io.data_in;
    end
  end

  if (FWFT == 0) begin : g_std_read
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (fifo_io.clr) begin
        dout_d = '0;
      end else if (rd_ok) begin
        dout_d = mem_q[rd_ptr_q];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else begin
        dout_q <= dout_d;
      end
    end

    assign fifo_io.data_out = dout_q;
  end else begin : g_fwft_read
    // Head word is presented continuously; meaningless while empty.
    assign fifo_io.data_out = mem_q[rd_ptr_q];
  end

  always_comb begin
    fifo_io.wr_ack      = wr_ack_q;
    fifo_io.overflow    = ovf_q;
    fifo_io.underflow   = udf_q;
    fifo_io.full        = full_w;
    fifo_io.empty       = empty_w;
    fifo_io.almostfull  = (count_q >= CntAf);
    fifo_io.almostempty = (count_q <= CntAe);
    fifo_io.count       = count_q;
    fifo_io.err_sticky  = err_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives three FIFO configurations with identical random stimulus and checks
// each against a queue-based reference model.
module tb_fifo_sync_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] din;

  always #5 clk = ~clk;

  fifo_sync_param_if #(.FIFO_WIDTH(16), .CW(4)) b0 ();
  fifo_sync_param_if #(.FIFO_WIDTH(16), .CW(3)) b1 ();
  fifo_sync_param_if #(.FIFO_WIDTH(16), .CW(3)) b2 ();

  assign b0.clr = clr;  assign b0.wr_en = wr_en;  assign b0.rd_en = rd_en;  assign b0.data_in = din;
  assign b1.clr = clr;  assign b1.wr_en = wr_en;  assign b1.rd_en = rd_en;  assign b1.data_in = din;
  assign b2.clr = clr;  assign b2.wr_en = wr_en;  assign b2.rd_en = rd_en;  assign b2.data_in = din;

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .fifo_io (b0)
  );

  fifo_sync_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .AE_LEVEL(2)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .fifo_io (b1)
  );

  fifo_sync_param #(
    .FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(0), .FWFT(1)
  ) u_dut2 (
    .clk     (clk),
    .rst     (rst),
    .fifo_io (b2)
  );

  logic [31:0] cnt_w  [3];
  logic [15:0] dout_w [3];
  logic [7:0]  flg_w  [3];

  assign cnt_w[0]  = 32'(b0.count);
  assign cnt_w[1]  = 32'(b1.count);
  assign cnt_w[2]  = 32'(b2.count);
  assign dout_w[0] = b0.data_out;
  assign dout_w[1] = b1.data_out;
  assign dout_w[2] = b2.data_out;
  assign flg_w[0]  = {b0.full, b0.empty, b0.almostfull, b0.almostempty,
                      b0.wr_ack, b0.overflow, b0.underflow, b0.err_sticky};
  assign flg_w[1]  = {b1.full, b1.empty, b1.almostfull, b1.almostempty,
                      b1.wr_ack, b1.overflow, b1.underflow, b1.err_sticky};
  assign flg_w[2]  = {b2.full, b2.empty, b2.almostfull, b2.almostempty,
                      b2.wr_ack, b2.overflow, b2.underflow, b2.err_sticky};

  // Reference model configuration and state, one slot per instance.
  int unsigned m_depth [3] = '{8, 5, 6};
  int unsigned m_af    [3] = '{7, 4, 4};
  int unsigned m_ae    [3] = '{1, 2, 0};
  int unsigned m_fw    [3] = '{0, 0, 1};
  logic [15:0] mq      [3][$];
  logic [15:0] m_dout  [3];
  logic        m_ack   [3];
  logic        m_ovf   [3];
  logic        m_udf   [3];
  logic        m_err   [3];

  string fname [8] = '{"underflow_n", "err_sticky", "underflow", "overflow", "wr_ack",
                       "almostempty", "almostfull", "empty"};

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      m_dout[i] = '0;
      m_ack[i]  = 1'b0;
      m_ovf[i]  = 1'b0;
      m_udf[i]  = 1'b0;
      m_err[i]  = 1'b0;
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        mq[i].delete();
        if (m_fw[i] == 0) m_dout[i] = '0;
        m_ack[i] = 1'b0;
        m_ovf[i] = 1'b0;
        m_udf[i] = 1'b0;
        m_err[i] = 1'b0;
      end else begin
        bit is_full, is_empty, wok, rok;
        logic [15:0] v;
        is_full  = (mq[i].size() == int'(m_depth[i]));
        is_empty = (mq[i].size() == 0);
        wok      = wr_en && !is_full;
        rok      = rd_en && !is_empty;
        m_ack[i] = wok;
        m_ovf[i] = wr_en && is_full;
        m_udf[i] = rd_en && is_empty;
        m_err[i] = m_err[i] | m_ovf[i] | m_udf[i];
        if (rok) begin
          v = mq[i].pop_front();
          if (m_fw[i] == 0) m_dout[i] = v;
        end
        if (wok) mq[i].push_back(din);
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int i = 0; i < 3; i++) begin
      int unsigned c;
      logic [7:0]  ef;
      c  = mq[i].size();
      ef = {c == m_depth[i], c == 0, c >= m_af[i], c <= m_ae[i],
            m_ack[i], m_ovf[i], m_udf[i], m_err[i]};
      check_eq($sformatf("%s.u%0d.count", ph, i), cnt_w[i], c);
      for (int b = 0; b < 7; b++) begin
        check_eq($sformatf("%s.u%0d.%s", ph, i, fname[b + 1]), 32'(flg_w[i][b]), 32'(ef[b]));
      end
      check_eq($sformatf("%s.u%0d.full", ph, i), 32'(flg_w[i][7]), 32'(ef[7]));
      if (m_fw[i] == 0) begin
        check_eq($sformatf("%s.u%0d.data_out", ph, i), 32'(dout_w[i]), 32'(m_dout[i]));
      end else if (c > 0) begin
        check_eq($sformatf("%s.u%0d.data_out", ph, i), 32'(dout_w[i]), 32'(mq[i][0]));
      end
    end
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    #1;
    check_all(ph);
  endtask

  int wp [4] = '{80, 20, 50, 95};
  int rp [4] = '{30, 85, 50, 95};

  initial begin
    rst   = 1'b1;
    clr   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    step("idle");
    step("idle");

    // Fill past capacity of every instance, last word should overflow u0.
    for (int k = 1; k <= 9; k++) begin
      wr_en = 1'b1;
      din   = (k == 9) ? 16'hDEAD : 16'(k);
      step("fill");
    end
    wr_en = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      rd_en = 1'b1;
      step("drain");
    end
    rd_en = 1'b0;
    step("drain_idle");

    for (int k = 0; k < 4; k++) begin
      wr_en = 1'b1;
      din   = 16'($urandom);
      step("prefill");
    end
    wr_en = 1'b0;
    clr   = 1'b1;
    step("clr");
    clr   = 1'b0;
    step("post_clr");

    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < 150; n++) begin
        wr_en = ($urandom_range(99) < 32'(wp[p]));
        rd_en = ($urandom_range(99) < 32'(rp[p]));
        clr   = ($urandom_range(99) == 0);
        din   = 16'($urandom);
        step("rand");
      end
    end
    clr   = 1'b0;
    rd_en = 1'b0;

    // Reset lands between edges with a write pending.
    wr_en = 1'b1;
    din   = 16'h1234;
    step("pre_arst");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    step("arst_hold");
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    step("arst_rel");
    step("arst_rel");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
